// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared branch-predictor types and constants
package bp_pkg;
  localparam int PC_W = 64;
  localparam logic [6:0] BRANCH_EQ = 7'b1100011;

  typedef struct packed {
    logic            valid;
    logic [PC_W-1:0] pc;
    logic            taken;
    logic [PC_W-1:0] target;
  } pred_meta_t;

  typedef enum logic {S_RUN, S_FLUSH} state_t;
endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end
endmodule

// File: rtl/branch_resolve_ctrl.sv
// rtl/branch_resolve_ctrl.sv - resolves IF-stage predictions in ID, drives redirect/flush,
// table updates and mispredict statistics
module branch_resolve_ctrl
  import bp_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             stall,
  input  logic             if_valid,
  input  logic [PC_W-1:0]  if_pc,
  input  logic             pred_taken,
  input  logic [PC_W-1:0]  pred_target,
  input  logic             id_is_branch,
  input  logic             id_taken,
  input  logic [PC_W-1:0]  id_target,
  output logic             redirect_valid,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             flush_if_id,
  output logic             upd_valid,
  output logic [PC_W-1:0]  upd_pc,
  output logic [PC_W-1:0]  upd_target,
  output logic             upd_taken,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);
  localparam int FC_W = $clog2(FLUSH_CYCLES + 1);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FLUSH_CYCLES - 1);

  state_t          state, state_n;
  logic [FC_W-1:0] fcnt, fcnt_n;
  pred_meta_t      meta;
  logic            res, br_mis, alias_mis, redirect, do_upd;

  assign res       = (state == S_RUN) && meta.valid && !stall;
  assign br_mis    = id_is_branch &&
                     ((meta.taken != id_taken) || (id_taken && (meta.target != id_target)));
  assign alias_mis = !id_is_branch && meta.taken;
  assign redirect  = res && (br_mis || alias_mis);
  assign do_upd    = res && id_is_branch;

  assign redirect_valid = redirect;
  assign flush_if_id    = redirect;

  always_comb begin
    redirect_pc = '0;
    if (redirect) begin
      redirect_pc = (br_mis && id_taken) ? id_target : meta.pc + 64'd4;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= S_RUN;
      fcnt  <= '0;
    end else begin
      state <= state_n;
      fcnt  <= fcnt_n;
    end
  end

  // The flush window counts real cycles; stall deliberately does not pause it.
  always_comb begin
    state_n = state;
    fcnt_n  = fcnt;
    case (state)
      S_RUN: begin
        if (redirect) begin
          state_n = S_FLUSH;
          fcnt_n  = '0;
        end
      end
      S_FLUSH: begin
        if (fcnt == FC_LAST) begin
          state_n = S_RUN;
          fcnt_n  = '0;
        end else begin
          fcnt_n = fcnt + 1'b1;
        end
      end
      default: begin
        state_n = S_RUN;
        fcnt_n  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      meta <= '0;
    end else if (redirect || (state == S_FLUSH)) begin
      meta.valid <= 1'b0;
    end else if (!stall) begin
      meta <= {if_valid, if_pc, pred_taken, pred_target};
    end
  end

  // Update payload is sticky between strobes so the table can sample it lazily.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      upd_valid  <= 1'b0;
      upd_pc     <= '0;
      upd_target <= '0;
      upd_taken  <= 1'b0;
    end else begin
      upd_valid <= do_upd;
      if (do_upd) begin
        upd_pc     <= meta.pc;
        upd_target <= id_target;
        upd_taken  <= id_taken;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_branch_cnt (
    .clk    (clk),
    .arst_n (arst_n),
    .inc    (do_upd),
    .clr    (1'b0),
    .q      (branch_cnt)
  );

  sat_counter #(.W(CNT_W)) u_mispred_cnt (
    .clk    (clk),
    .arst_n (arst_n),
    .inc    (redirect),
    .clr    (1'b0),
    .q      (mispred_cnt)
  );
endmodule
